// File: rtl/kanji_rom_ctrl_pkg.sv
// ============================================================================
// Module   : kanji_rom_ctrl_pkg
// Purpose  : Shared types and constants for the kanji ROM controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package kanji_rom_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_e;

  localparam int LEVEL_SPAN = 1 << 17;
  localparam int SIZE_UNIT  = 1 << 14;
  localparam int ADDR_W     = 27;
  localparam int OFS_W      = 17;

endpackage

`default_nettype wire

// File: rtl/kanji_rom_ctrl_level.sv
// ============================================================================
// Module   : kanji_level
// Purpose  : One ROM level: offset register, one-byte read buffer and flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module kanji_level
  import kanji_rom_ctrl_pkg::*;
#(
  parameter int CHAR_BYTES = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_lo_i,
  input  logic             wr_hi_i,
  input  logic             hangul_i,
  input  logic [6:0]       data_i,
  input  logic             rd_i,
  input  logic             issue_i,
  input  logic             ack_i,
  input  logic [7:0]       ram_data_i,
  output logic [OFS_W-1:0] ofs_o,
  output logic [7:0]       buf_o,
  output logic             valid_o,
  output logic             pend_o
);

  localparam int CB = $clog2(CHAR_BYTES);

  logic [OFS_W-1:0] ofs_q, ofs_d;
  logic [7:0]       buf_q, buf_d;
  logic             valid_q, valid_d;
  logic             pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             stale_q, stale_d;
  logic             w_wr;

  assign w_wr = wr_lo_i | wr_hi_i;

  always_comb begin
    ofs_d   = ofs_q;
    buf_d   = buf_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    stale_d = stale_q;

    if (issue_i) begin
      pend_d = 1'b0;
      busy_d = 1'b1;
    end

    // A fetch whose level was re-addressed in flight returns an obsolete byte.
    if (ack_i) begin
      busy_d  = 1'b0;
      stale_d = 1'b0;
      if (!stale_q && !w_wr) begin
        buf_d   = ram_data_i;
        valid_d = 1'b1;
      end
    end

    if (rd_i) begin
      ofs_d[CB-1:0] = ofs_q[CB-1:0] + CB'(1);
      valid_d       = 1'b0;
      pend_d        = 1'b1;
    end

    if (wr_lo_i) begin
      ofs_d[4:0] = '0;
      if (hangul_i) begin
        ofs_d[11:5] = data_i[6:0];
      end else begin
        ofs_d[10:5] = data_i[5:0];
      end
    end

    if (wr_hi_i) begin
      ofs_d[16:11] = data_i[5:0];
      ofs_d[4:0]   = '0;
    end

    if (w_wr) begin
      valid_d = 1'b0;
      pend_d  = 1'b1;
      if (busy_q && !ack_i) begin
        stale_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ofs_q   <= '0;
      buf_q   <= 8'hFF;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      stale_q <= 1'b0;
    end else begin
      ofs_q   <= ofs_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      stale_q <= stale_d;
    end
  end

  assign ofs_o   = ofs_q;
  assign buf_o   = buf_q;
  assign valid_o = valid_q;
  assign pend_o  = pend_q;

endmodule

`default_nettype wire

// File: rtl/kanji_rom_ctrl.sv
// ============================================================================
// Module   : kanji_rom_ctrl
// Purpose  : Kanji ROM IO-port front end fetching glyph bytes from SDRAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module kanji_rom_ctrl
  import kanji_rom_ctrl_pkg::*;
#(
  parameter int LEVELS     = 2,
  parameter int CHAR_BYTES = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req,
  input  logic                        wr,
  input  logic                        rd,
  input  logic [$clog2(2*LEVELS)-1:0] port_sel,
  input  logic [7:0]                  data_in,
  output logic [7:0]                  data_out,
  output logic                        wait_n,
  input  logic [ADDR_W-1:0]           ram_base,
  input  logic [7:0]                  ram_size,
  input  logic                        hangul,
  output logic                        ram_rd,
  output logic [ADDR_W-1:0]           ram_addr,
  input  logic                        ram_ack,
  input  logic [7:0]                  ram_data
);

  localparam int PSW       = $clog2(2*LEVELS);
  localparam int LIDX_W    = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam int LVL_UNITS = LEVEL_SPAN / SIZE_UNIT;

  fetch_state_e      state_q, state_d;
  logic [LIDX_W-1:0] sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [PSW-1:0]    w_lvl;
  logic [OFS_W-1:0]  w_ofs [LEVELS];
  logic [7:0]        w_buf [LEVELS];
  logic [LEVELS-1:0] w_valid, w_pend, w_present, w_hit;
  logic [LEVELS-1:0] w_wr_lo, w_wr_hi, w_rd_ok, w_issue, w_ack;
  logic              w_found;
  logic              unused_w;

  assign w_lvl    = port_sel >> 1;
  assign unused_w = data_in[7];

  always_comb begin
    w_hit     = '0;
    w_present = '0;
    w_wr_lo   = '0;
    w_wr_hi   = '0;
    w_rd_ok   = '0;
    for (int k = 0; k < LEVELS; k++) begin
      w_hit[k]     = (int'(w_lvl) == k);
      w_present[k] = (int'(ram_size) > k * LVL_UNITS);
      w_wr_lo[k]   = req & wr & w_hit[k] & ~port_sel[0];
      w_wr_hi[k]   = req & wr & w_hit[k] & port_sel[0];
      w_rd_ok[k]   = req & rd & w_hit[k] & port_sel[0] & w_present[k] & w_valid[k];
    end
  end

  always_comb begin
    data_out = 8'hFF;
    wait_n   = 1'b1;
    for (int k = 0; k < LEVELS; k++) begin
      if (rd && port_sel[0] && w_hit[k] && w_present[k]) begin
        if (w_valid[k]) begin
          data_out = w_buf[k];
        end else begin
          wait_n = 1'b0;
        end
      end
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    kanji_level #(
      .CHAR_BYTES (CHAR_BYTES)
    ) u_level (
      .clk        (clk),
      .reset      (reset),
      .wr_lo_i    (w_wr_lo[k]),
      .wr_hi_i    (w_wr_hi[k]),
      .hangul_i   ((k == 1) ? hangul : 1'b0),
      .data_i     (data_in[6:0]),
      .rd_i       (w_rd_ok[k]),
      .issue_i    (w_issue[k]),
      .ack_i      (w_ack[k]),
      .ram_data_i (ram_data),
      .ofs_o      (w_ofs[k]),
      .buf_o      (w_buf[k]),
      .valid_o    (w_valid[k]),
      .pend_o     (w_pend[k])
    );
  end

  // A level being addressed this cycle is skipped so the fetch sees its final offset.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    w_issue = '0;
    w_ack   = '0;
    w_found = 1'b0;
    case (state_q)
      ST_IDLE: begin
        for (int k = 0; k < LEVELS; k++) begin
          if (!w_found && w_pend[k] && w_present[k] && !(w_wr_lo[k] || w_wr_hi[k])) begin
            w_found    = 1'b1;
            w_issue[k] = 1'b1;
            sel_d      = LIDX_W'(k);
            addr_d     = ram_base + ADDR_W'(k * LEVEL_SPAN) + ADDR_W'(w_ofs[k]);
            state_d    = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (ram_ack) begin
          for (int k = 0; k < LEVELS; k++) begin
            w_ack[k] = (sel_q == LIDX_W'(k));
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      addr_q  <= '1;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
    end
  end

  assign ram_rd   = (state_q == ST_FETCH);
  assign ram_addr = ram_rd ? addr_q : '1;

endmodule

`default_nettype wire

// File: tb/tb_kanji_rom_ctrl.sv
// ============================================================================
// Module   : tb_kanji_rom_ctrl
// Purpose  : Directed self-checking bench for kanji_rom_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_kanji_rom_ctrl;

  logic        clk = 1'b0;
  logic        reset, req, wr, rd, hangul;
  logic [1:0]  port_sel;
  logic [7:0]  data_in, data_out, ram_size, ram_data;
  logic        wait_n, ram_rd, ram_ack;
  logic [26:0] ram_base, ram_addr;

  logic        resp_ack, man_ack;
  logic [7:0]  resp_data, man_data;
  bit          auto_en;
  int          lat;
  int          nfetch;
  logic [26:0] last_addr;
  logic        rd_prev;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign ram_ack  = resp_ack | man_ack;
  assign ram_data = man_ack ? man_data : resp_data;

  kanji_rom_ctrl #(
    .LEVELS     (2),
    .CHAR_BYTES (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .wr       (wr),
    .rd       (rd),
    .port_sel (port_sel),
    .data_in  (data_in),
    .data_out (data_out),
    .wait_n   (wait_n),
    .ram_base (ram_base),
    .ram_size (ram_size),
    .hangul   (hangul),
    .ram_rd   (ram_rd),
    .ram_addr (ram_addr),
    .ram_ack  (ram_ack),
    .ram_data (ram_data)
  );

  function automatic logic [7:0] mdata(input logic [26:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // SDRAM model: acknowledges a held ram_rd after lat cycles.
  initial begin
    int cnt;
    cnt       = 0;
    resp_ack  = 1'b0;
    resp_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (resp_ack) begin
        resp_ack = 1'b0;
        cnt      = 0;
      end else if (auto_en && ram_rd === 1'b1) begin
        cnt++;
        if (cnt >= lat) begin
          resp_ack  = 1'b1;
          resp_data = mdata(ram_addr);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    nfetch    = 0;
    rd_prev   = 1'b0;
    last_addr = '0;
    forever begin
      @(negedge clk);
      if (ram_rd === 1'b1 && rd_prev !== 1'b1) begin
        nfetch++;
        last_addr = ram_addr;
      end
      rd_prev = ram_rd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] sel, input logic [7:0] d);
    port_sel = sel;
    data_in  = d;
    req      = 1'b1;
    wr       = 1'b1;
    tick();
    req      = 1'b0;
    wr       = 1'b0;
  endtask

  task automatic read_wait(input logic [1:0] sel, output logic [7:0] d, output bit ok);
    ok       = 1'b0;
    d        = 8'h00;
    port_sel = sel;
    req      = 1'b1;
    rd       = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (wait_n === 1'b1) begin
        d  = data_out;
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    req = 1'b0;
    rd  = 1'b0;
  endtask

  task automatic wait_rd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ram_rd === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; wr = 1'b0; rd = 1'b0; port_sel = 2'd0; data_in = 8'h00;
    hangul = 1'b0; man_ack = 1'b0; man_data = 8'h00; auto_en = 1'b1; lat = 3;
    ram_base = 27'h0100000; ram_size = 8'd16;
    repeat (3) tick();
    n_cmp++; if (ram_rd !== 1'b0) begin n_bad++; $display("FAIL reset_ram_rd: got %b want 0", ram_rd); end
    n_cmp++; if (ram_addr !== 27'h7FFFFFF) begin n_bad++; $display("FAIL reset_ram_addr: got %h want 7ffffff", ram_addr); end
    n_cmp++; if (data_out !== 8'hFF) begin n_bad++; $display("FAIL reset_data_out: got %h want ff", data_out); end
    n_cmp++; if (wait_n !== 1'b1) begin n_bad++; $display("FAIL reset_wait_n: got %b want 1", wait_n); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    int f0;
    logic [7:0] d;
    bit ok;
    f0 = nfetch;
    cpu_write(2'd0, 8'h05);
    cpu_write(2'd1, 8'h02);
    repeat (8) tick();
    n_cmp++; if (nfetch - f0 !== 1) begin n_bad++; $display("FAIL fetch_count: got %0d want 1", nfetch - f0); end
    n_cmp++; if (last_addr !== 27'h01010A0) begin n_bad++; $display("FAIL fetch_addr: got %h want 01010a0", last_addr); end
    read_wait(2'd1, d, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL fetch_valid: got wait timeout want data"); end
    n_cmp++; if (d !== 8'h8C) begin n_bad++; $display("FAIL fetch_data: got %h want 8c", d); end
  endtask

  task automatic test_wrap();
    logic [7:0]  d;
    logic [26:0] a;
    bit ok;
    for (int i = 1; i <= 32; i++) begin
      read_wait(2'd1, d, ok);
      a = 27'h01010A0 + 27'(i % 32);
      n_cmp++;
      if (!ok || d !== mdata(a)) begin
        n_bad++;
        $display("FAIL wrap_read%0d: got %h ok=%0d want %h", i, d, ok, mdata(a));
      end
    end
    repeat (8) tick();
    n_cmp++; if (last_addr !== 27'h01010A1) begin n_bad++; $display("FAIL wrap_prefetch_addr: got %h want 01010a1", last_addr); end
  endtask

  task automatic test_wait();
    logic [7:0] d;
    bit ok;
    lat = 5;
    cpu_write(2'd0, 8'h07);
    port_sel = 2'd1; req = 1'b1; rd = 1'b1;
    #1;
    n_cmp++; if (wait_n !== 1'b0) begin n_bad++; $display("FAIL wait_low: got %b want 0", wait_n); end
    tick();
    req = 1'b0; rd = 1'b0;
    read_wait(2'd1, d, ok);
    n_cmp++; if (!ok || d !== 8'hCC) begin n_bad++; $display("FAIL wait_data: got %h ok=%0d want cc", d, ok); end
    read_wait(2'd1, d, ok);
    n_cmp++; if (!ok || d !== 8'hCD) begin n_bad++; $display("FAIL wait_no_double_inc: got %h ok=%0d want cd", d, ok); end
    lat = 3;
  endtask

  task automatic test_absent();
    int f0;
    logic [7:0] d;
    bit ok;
    repeat (8) tick();
    ram_size = 8'd8;
    f0 = nfetch;
    cpu_write(2'd2, 8'h01);
    repeat (10) tick();
    port_sel = 2'd3; req = 1'b1; rd = 1'b1;
    #1;
    n_cmp++; if (data_out !== 8'hFF) begin n_bad++; $display("FAIL absent_data: got %h want ff", data_out); end
    n_cmp++; if (wait_n !== 1'b1) begin n_bad++; $display("FAIL absent_wait_n: got %b want 1", wait_n); end
    tick();
    port_sel = 2'd0;
    #1;
    n_cmp++; if (data_out !== 8'hFF || wait_n !== 1'b1) begin n_bad++; $display("FAIL low_port_read: got %h/%b want ff/1", data_out, wait_n); end
    tick();
    req = 1'b0; rd = 1'b0;
    n_cmp++; if (nfetch !== f0) begin n_bad++; $display("FAIL absent_no_fetch: got %0d want %0d", nfetch, f0); end
    ram_size = 8'd16;
    repeat (10) tick();
    read_wait(2'd3, d, ok);
    n_cmp++; if (!ok || d !== 8'h1C) begin n_bad++; $display("FAIL level1_data: got %h ok=%0d want 1c", d, ok); end
  endtask

  task automatic test_collision();
    logic [7:0] d;
    bit ok;
    repeat (8) tick();
    auto_en = 1'b0;
    cpu_write(2'd0, 8'h09);
    wait_rd(ok);
    n_cmp++; if (!ok || ram_addr !== 27'h0101120) begin n_bad++; $display("FAIL coll_first_addr: got %h ok=%0d want 0101120", ram_addr, ok); end
    man_ack = 1'b1; man_data = 8'hEE;
    port_sel = 2'd0; data_in = 8'h0A; req = 1'b1; wr = 1'b1;
    tick();
    man_ack = 1'b0; req = 1'b0; wr = 1'b0;
    port_sel = 2'd1; req = 1'b1; rd = 1'b1;
    #1;
    n_cmp++; if (wait_n !== 1'b0) begin n_bad++; $display("FAIL coll_discard: got wait_n %b want 0", wait_n); end
    tick();
    req = 1'b0; rd = 1'b0;
    wait_rd(ok);
    n_cmp++; if (!ok || ram_addr !== 27'h0101140) begin n_bad++; $display("FAIL coll_refetch_addr: got %h ok=%0d want 0101140", ram_addr, ok); end
    man_ack = 1'b1; man_data = 8'h77;
    tick();
    man_ack = 1'b0;
    read_wait(2'd1, d, ok);
    n_cmp++; if (!ok || d !== 8'h77) begin n_bad++; $display("FAIL coll_data: got %h ok=%0d want 77", d, ok); end
    auto_en = 1'b1;
  endtask

  task automatic test_reset_fetch();
    int f0;
    bit ok;
    repeat (8) tick();
    auto_en = 1'b0;
    cpu_write(2'd0, 8'h0B);
    wait_rd(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_fetch_start: got no ram_rd want ram_rd"); end
    reset = 1'b1;
    tick();
    n_cmp++; if (ram_rd !== 1'b0) begin n_bad++; $display("FAIL rst_ram_rd_drop: got %b want 0", ram_rd); end
    reset = 1'b0;
    man_ack = 1'b1; man_data = 8'h55;
    tick();
    man_ack = 1'b0;
    f0 = nfetch;
    repeat (5) tick();
    n_cmp++; if (ram_rd !== 1'b0 || nfetch !== f0) begin n_bad++; $display("FAIL rst_no_refetch: got ram_rd %b fetches %0d want 0 %0d", ram_rd, nfetch, f0); end
    n_cmp++; if (ram_addr !== 27'h7FFFFFF) begin n_bad++; $display("FAIL rst_ram_addr: got %h want 7ffffff", ram_addr); end
    port_sel = 2'd1; req = 1'b1; rd = 1'b1;
    #1;
    n_cmp++; if (wait_n !== 1'b0) begin n_bad++; $display("FAIL rst_v0_clear: got wait_n %b want 0", wait_n); end
    port_sel = 2'd3;
    #1;
    n_cmp++; if (wait_n !== 1'b0) begin n_bad++; $display("FAIL rst_v1_clear: got wait_n %b want 0", wait_n); end
    tick();
    req = 1'b0; rd = 1'b0;
    auto_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_wrap();
    test_wait();
    test_absent();
    test_collision();
    test_reset_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
